// File: rtl/clock_time_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// clock_time_ctrl
//
// Time-of-day controller for the clock display path. Keeps hours, minutes
// and seconds as BCD counters advanced by the rising edges of a 1 Hz
// square wave. A four-state mode machine, stepped by the key_mode pulse,
// freezes the timebase and lets key_inc adjust one field at a time.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sec_in      1 Hz square wave, synchronous to clk
//   key_mode    debounced one-cycle pulse, advances the mode
//   key_inc     debounced one-cycle pulse, adjusts the selected field
//   hour_bcd    hours   (BCD, [7:4] tens, [3:0] units)
//   min_bcd     minutes (BCD)
//   sec_bcd     seconds (BCD)
//   set_mode    0 = RUN, 1 = SET_HR, 2 = SET_MIN, 3 = SET_SEC
//   sec_strobe  one-cycle pulse after the time advanced in RUN
//   day_pulse   one-cycle pulse after the wrap HOUR_MAX:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module clock_time_ctrl #(
    parameter logic [7:0] HOUR_MAX   = 8'h23,
    parameter logic [7:0] RESET_HOUR = 8'h12,
    parameter logic [7:0] RESET_MIN  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_in,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] set_mode,
    output logic       sec_strobe,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    mode_t      state;
    logic       sec_d;
    logic       tick;
    logic [8:0] sec_next;
    logic [8:0] min_next;
    logic [8:0] hour_next;

    // BCD increment with wrap. Bit 8 of the result is the wrap/carry flag,
    // bits 7:0 the new BCD value (00 on wrap).
    function automatic logic [8:0] bcd_inc(input logic [7:0] value,
                                           input logic [7:0] last);
        logic [8:0] result;
        if (value == last)
            result = 9'h100;
        else if (value[3:0] == 4'd9)
            result = {1'b0, value[7:4] + 4'd1, 4'd0};
        else
            result = {1'b0, value[7:4], value[3:0] + 4'd1};
        return result;
    endfunction

    // sec_d resets high so a timebase already high at reset release does
    // not count as a second.
    assign tick      = sec_in & ~sec_d;
    assign sec_next  = bcd_inc(sec_bcd, 8'h59);
    assign min_next  = bcd_inc(min_bcd, 8'h59);
    assign hour_next = bcd_inc(hour_bcd, HOUR_MAX);
    assign set_mode  = state;

    // Mode machine and time counters. In RUN a tick ripples the full
    // sec -> min -> hour carry in one clock and is applied before any
    // coincident key_mode takes effect. In the SET states the timebase is
    // ignored and key_mode always wins over key_inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            sec_d      <= 1'b1;
            hour_bcd   <= RESET_HOUR;
            min_bcd    <= RESET_MIN;
            sec_bcd    <= 8'h00;
            sec_strobe <= 1'b0;
            day_pulse  <= 1'b0;
        end else begin
            sec_d      <= sec_in;
            sec_strobe <= 1'b0;
            day_pulse  <= 1'b0;
            case (state)
                RUN: begin
                    if (tick) begin
                        sec_strobe <= 1'b1;
                        sec_bcd    <= sec_next[7:0];
                        if (sec_next[8]) begin
                            min_bcd <= min_next[7:0];
                            if (min_next[8]) begin
                                hour_bcd  <= hour_next[7:0];
                                day_pulse <= hour_next[8];
                            end
                        end
                    end
                    if (key_mode)
                        state <= SET_HR;
                end
                SET_HR: begin
                    if (key_mode)
                        state <= SET_MIN;
                    else if (key_inc)
                        hour_bcd <= hour_next[7:0];
                end
                SET_MIN: begin
                    if (key_mode)
                        state <= SET_SEC;
                    else if (key_inc)
                        min_bcd <= min_next[7:0];
                end
                SET_SEC: begin
                    if (key_mode)
                        state <= RUN;
                    else if (key_inc)
                        sec_bcd <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_clock_time_ctrl
//
// Drives a 24-hour build and a 12-hour build of clock_time_ctrl from the
// same inputs. A reference model keeps the time as plain integers and
// pushes the expected outputs into a queue for every driven cycle; a
// monitor pops one entry per clock and compares it with both DUTs.
// ---------------------------------------------------------------------------
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sec_in;
    logic       key_mode;
    logic       key_inc;
    logic [7:0] hour0, min0, sec0, hour1, min1, sec1;
    logic [1:0] mode0, mode1;
    logic       strobe0, strobe1, day0, day1;

    typedef struct packed {
        logic [7:0] h0, m0, s0, h1, m1, s1;
        logic [1:0] mode;
        logic       strobe, dp0, dp1;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: one time per build, shared mode and timebase.
    int   mh[2], mm[2], ms[2];
    int   hmax[2]    = '{23, 11};
    int   resetH[2]  = '{12, 11};
    int   resetM[2]  = '{0, 59};
    int   mode;
    bit   prevSec;
    bit   secLevel;

    clock_time_ctrl #(.HOUR_MAX(8'h23), .RESET_HOUR(8'h12), .RESET_MIN(8'h00)) dut24 (
        .clk(clk), .rst_n(rst_n), .sec_in(sec_in), .key_mode(key_mode),
        .key_inc(key_inc), .hour_bcd(hour0), .min_bcd(min0), .sec_bcd(sec0),
        .set_mode(mode0), .sec_strobe(strobe0), .day_pulse(day0)
    );

    clock_time_ctrl #(.HOUR_MAX(8'h11), .RESET_HOUR(8'h11), .RESET_MIN(8'h59)) dut12 (
        .clk(clk), .rst_n(rst_n), .sec_in(sec_in), .key_mode(key_mode),
        .key_inc(key_inc), .hour_bcd(hour1), .min_bcd(min1), .sec_bcd(sec1),
        .set_mode(mode1), .sec_strobe(strobe1), .day_pulse(day1)
    );

    // 100 MHz bench clock; the design only cares about edges.
    always #5 clk = ~clk;

    function automatic logic [7:0] toBcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // One comparison with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mh[i] = resetH[i];
            mm[i] = resetM[i];
            ms[i] = 0;
        end
        mode    = 0;
        prevSec = 1'b1;
    endtask

    // Advance the model by one clock given the inputs, push what the DUTs
    // must show after that clock edge.
    task automatic modelStep(input bit s, input bit km, input bit ki);
        exp_t e;
        bit   tick, strobe;
        bit   dp[2];
        tick    = s && !prevSec;
        prevSec = s;
        strobe  = 1'b0;
        dp[0]   = 1'b0;
        dp[1]   = 1'b0;
        case (mode)
            0: begin
                if (tick) begin
                    strobe = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        ms[i]++;
                        if (ms[i] == 60) begin
                            ms[i] = 0;
                            mm[i]++;
                            if (mm[i] == 60) begin
                                mm[i] = 0;
                                if (mh[i] == hmax[i]) begin
                                    mh[i] = 0;
                                    dp[i] = 1'b1;
                                end else begin
                                    mh[i]++;
                                end
                            end
                        end
                    end
                end
                if (km) mode = 1;
            end
            1: begin
                if (km) mode = 2;
                else if (ki)
                    for (int i = 0; i < 2; i++) mh[i] = (mh[i] == hmax[i]) ? 0 : mh[i] + 1;
            end
            2: begin
                if (km) mode = 3;
                else if (ki)
                    for (int i = 0; i < 2; i++) mm[i] = (mm[i] + 1) % 60;
            end
            default: begin
                if (km) mode = 0;
                else if (ki)
                    for (int i = 0; i < 2; i++) ms[i] = 0;
            end
        endcase
        e.h0 = toBcd(mh[0]); e.m0 = toBcd(mm[0]); e.s0 = toBcd(ms[0]);
        e.h1 = toBcd(mh[1]); e.m1 = toBcd(mm[1]); e.s1 = toBcd(ms[1]);
        e.mode   = 2'(mode);
        e.strobe = strobe;
        e.dp0    = dp[0];
        e.dp1    = dp[1];
        expQ.push_back(e);
    endtask

    // Drive inputs for the coming clock edge and record the expectation.
    task automatic driveNow(input bit s, input bit km, input bit ki);
        sec_in   = s;
        key_mode = km;
        key_inc  = ki;
        secLevel = s;
        modelStep(s, km, ki);
    endtask

    task automatic applyStimulus(input bit s, input bit km, input bit ki);
        @(negedge clk);
        driveNow(s, km, ki);
    endtask

    task automatic pressMode();
        applyStimulus(secLevel, 1'b1, 1'b0);
        applyStimulus(secLevel, 1'b0, 1'b0);
    endtask

    task automatic pressInc();
        applyStimulus(secLevel, 1'b0, 1'b1);
        applyStimulus(secLevel, 1'b0, 1'b0);
    endtask

    task automatic gotoMode(input int target);
        for (int i = 0; i < 4 && mode != target; i++) pressMode();
    endtask

    task automatic setHour(input int target);
        gotoMode(1);
        for (int i = 0; i < 24 && mh[0] != target; i++) pressInc();
    endtask

    task automatic setMin(input int target);
        gotoMode(2);
        for (int i = 0; i < 60 && mm[0] != target; i++) pressInc();
    endtask

    // n full periods of the timebase, each with exactly one rising edge.
    task automatic ticks(input int n);
        if (secLevel) applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Direct comparison of every output against the model's reset state,
    // used while rst_n is low and no clock edge has been seen.
    task automatic checkResetState();
        checkOutput("rst_hour24", hour0, toBcd(mh[0]));
        checkOutput("rst_min24", min0, toBcd(mm[0]));
        checkOutput("rst_sec24", sec0, toBcd(ms[0]));
        checkOutput("rst_mode24", {6'd0, mode0}, 8'(mode));
        checkOutput("rst_strobe24", {7'd0, strobe0}, 8'h00);
        checkOutput("rst_day24", {7'd0, day0}, 8'h00);
        checkOutput("rst_hour12", hour1, toBcd(mh[1]));
        checkOutput("rst_min12", min1, toBcd(mm[1]));
        checkOutput("rst_sec12", sec1, toBcd(ms[1]));
        checkOutput("rst_mode12", {6'd0, mode1}, 8'(mode));
    endtask

    // Scoreboard monitor: one expectation per clock edge, compared shortly
    // after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("hour24", hour0, e.h0);
                checkOutput("min24", min0, e.m0);
                checkOutput("sec24", sec0, e.s0);
                checkOutput("mode24", {6'd0, mode0}, {6'd0, e.mode});
                checkOutput("strobe24", {7'd0, strobe0}, {7'd0, e.strobe});
                checkOutput("day24", {7'd0, day0}, {7'd0, e.dp0});
                checkOutput("hour12", hour1, e.h1);
                checkOutput("min12", min1, e.m1);
                checkOutput("sec12", sec1, e.s1);
                checkOutput("mode12", {6'd0, mode1}, {6'd0, e.mode});
                checkOutput("strobe12", {7'd0, strobe1}, {7'd0, e.strobe});
                checkOutput("day12", {7'd0, day1}, {7'd0, e.dp1});
            end
        end
    end

    initial begin
        int r;
        bit s, km, ki;

        // Reset with the timebase already high; release must not count it.
        rst_n    = 1'b0;
        sec_in   = 1'b1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        secLevel = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        driveNow(1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        ticks(1);
        $display("[TB] reset release and first second done");

        // Set 23:59:00 and run into the day wrap.
        setHour(23);
        setMin(59);
        gotoMode(3);
        pressInc();
        gotoMode(0);
        ticks(59);
        ticks(1);
        $display("[TB] 24-hour day wrap done");

        // Timebase ignored in SET_MIN, including a tick coincident with key_inc.
        gotoMode(2);
        ticks(5);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Hour wrap in SET_HR does not touch minutes.
        setMin(45);
        setHour(23);
        pressInc();

        // 10:20:30, then key_mode together with key_inc in SET_HR.
        setHour(10);
        setMin(20);
        gotoMode(3);
        pressInc();
        gotoMode(0);
        ticks(30);
        gotoMode(1);
        applyStimulus(secLevel, 1'b1, 1'b1);
        applyStimulus(secLevel, 1'b0, 1'b0);

        // Tick together with key_mode in RUN, and a tick swallowed by the
        // SET_SEC -> RUN transition.
        gotoMode(0);
        ticks(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoMode(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks(2);
        $display("[TB] simultaneous-event cases done");

        // Asynchronous reset in the middle of setting 07:33:00.
        setHour(7);
        setMin(33);
        gotoMode(3);
        pressInc();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResetState();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        driveNow(secLevel, 1'b0, 1'b0);

        // 12-hour build starts at 11:59:00 and wraps to 00:00:00 here.
        ticks(60);
        $display("[TB] async reset and 12-hour wrap done");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            s  = ($urandom_range(0, 5) == 0) ? ~secLevel : secLevel;
            km = (r < 4);
            ki = (r >= 4 && r < 30);
            applyStimulus(s, km, ki);
        end
        applyStimulus(secLevel, 1'b0, 1'b0);

        // Every expectation must have been consumed by the monitor.
        @(posedge clk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
